// File: rtl/glitch_sequencer_if.sv
// Host/config and glitch_core bus for glitch_sequencer.
//   master: host side; drives arm/abort/trigger and the live config, observes status.
//   slave : sequencer side; samples commands/config, drives gl_en/gl_mode and status.
interface glitch_sequencer_if #(
    parameter int unsigned DELAY_W = 32,
    parameter int unsigned WIDTH_W = 16,
    parameter int unsigned COUNT_W = 8
);
    // commands
    logic               arm;
    logic               abort;
    logic               trigger;

    // live configuration, captured on an accepted arm
    logic [DELAY_W-1:0] cfg_delay;
    logic [WIDTH_W-1:0] cfg_width;
    logic [WIDTH_W-1:0] cfg_gap;
    logic [COUNT_W-1:0] cfg_count;
    logic [7:0]         cfg_mode;
    logic               cfg_rearm;

    // glitch_core drive and status
    logic               gl_en;
    logic [7:0]         gl_mode;
    logic               armed;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] pulse_cnt;

    modport master (
        output arm, abort, trigger,
        output cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_mode, cfg_rearm,
        input  gl_en, gl_mode, armed, busy, done, pulse_cnt
    );

    modport slave (
        input  arm, abort, trigger,
        input  cfg_delay, cfg_width, cfg_gap, cfg_count, cfg_mode, cfg_rearm,
        output gl_en, gl_mode, armed, busy, done, pulse_cnt
    );
endinterface

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: schedules glitch windows for glitch_core.
// After arm and a synchronised rising edge on trigger, waits cfg_delay cycles,
// then issues cfg_count windows of cfg_width cycles separated by cfg_gap cycles.
// Ports:
//   clk_in : clock, all logic on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : glitch_sequencer_if.slave
//            in : arm, abort, trigger, cfg_delay/width/gap/count/mode/rearm
//            out: gl_en, gl_mode (registered, to glitch_core en/mode),
//                 armed, busy (state decode), done (1-cycle), pulse_cnt
module glitch_sequencer #(
    parameter int unsigned DELAY_W     = 32,
    parameter int unsigned WIDTH_W     = 16,
    parameter int unsigned COUNT_W     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_in,
    input  logic                rst_n,
    glitch_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_PULSE = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t                 state;

    // trigger synchroniser and edge detector
    logic [SYNC_STAGES-1:0] sync;
    logic                   trig_prev;
    logic                   trig_rise;

    // shadow configuration; zero width/gap/count already mapped to 1
    logic [DELAY_W-1:0]     sh_delay;
    logic [WIDTH_W-1:0]     sh_width_m1;
    logic [WIDTH_W-1:0]     sh_gap_m1;
    logic [COUNT_W-1:0]     sh_count;
    logic [7:0]             sh_mode;
    logic                   sh_rearm;

    // run-time counters
    logic [DELAY_W-1:0]     dly_cnt;
    logic [WIDTH_W-1:0]     win_cnt;
    logic [COUNT_W-1:0]     pulse_cnt;

    // registered outputs
    logic                   gl_en;
    logic [7:0]             gl_mode;
    logic                   done;

    // Synchroniser: stage 0 samples the asynchronous trigger.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= '0;
            trig_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], bus.trigger};
            trig_prev <= sync[SYNC_STAGES-1];
        end
    end

    // A level that is already high when armed never produces a rise here.
    assign trig_rise = sync[SYNC_STAGES-1] & ~trig_prev;

    // Sequencer FSM with registered glitch_core drive.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sh_delay    <= '0;
            sh_width_m1 <= '0;
            sh_gap_m1   <= '0;
            sh_count    <= '0;
            sh_mode     <= '0;
            sh_rearm    <= 1'b0;
            dly_cnt     <= '0;
            win_cnt     <= '0;
            pulse_cnt   <= '0;
            gl_en       <= 1'b0;
            gl_mode     <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.abort) begin
                // Abort overrides everything including a same-cycle arm;
                // pulse_cnt keeps the number of windows already issued.
                state   <= S_IDLE;
                gl_en   <= 1'b0;
                gl_mode <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (bus.arm) begin
                            sh_delay    <= bus.cfg_delay;
                            sh_width_m1 <= (bus.cfg_width == '0) ? '0
                                           : bus.cfg_width - WIDTH_W'(1);
                            sh_gap_m1   <= (bus.cfg_gap == '0) ? '0
                                           : bus.cfg_gap - WIDTH_W'(1);
                            sh_count    <= (bus.cfg_count == '0) ? COUNT_W'(1)
                                           : bus.cfg_count;
                            sh_mode     <= bus.cfg_mode;
                            sh_rearm    <= bus.cfg_rearm;
                            pulse_cnt   <= '0;
                            state       <= S_ARMED;
                        end
                    end

                    S_ARMED: begin
                        if (trig_rise) begin
                            dly_cnt   <= sh_delay;
                            pulse_cnt <= '0;
                            state     <= S_DELAY;
                        end
                    end

                    S_DELAY: begin
                        if (dly_cnt == '0) begin
                            state     <= S_PULSE;
                            gl_en     <= 1'b1;
                            gl_mode   <= sh_mode;
                            win_cnt   <= sh_width_m1;
                            pulse_cnt <= pulse_cnt + COUNT_W'(1);
                        end else begin
                            dly_cnt <= dly_cnt - DELAY_W'(1);
                        end
                    end

                    S_PULSE: begin
                        if (win_cnt == '0) begin
                            gl_en   <= 1'b0;
                            gl_mode <= '0;
                            if (pulse_cnt == sh_count) begin
                                done  <= 1'b1;
                                state <= sh_rearm ? S_ARMED : S_IDLE;
                            end else begin
                                win_cnt <= sh_gap_m1;
                                state   <= S_GAP;
                            end
                        end else begin
                            win_cnt <= win_cnt - WIDTH_W'(1);
                        end
                    end

                    S_GAP: begin
                        if (win_cnt == '0) begin
                            state     <= S_PULSE;
                            gl_en     <= 1'b1;
                            gl_mode   <= sh_mode;
                            win_cnt   <= sh_width_m1;
                            pulse_cnt <= pulse_cnt + COUNT_W'(1);
                        end else begin
                            win_cnt <= win_cnt - WIDTH_W'(1);
                        end
                    end

                    default: begin
                        state   <= S_IDLE;
                        gl_en   <= 1'b0;
                        gl_mode <= '0;
                    end
                endcase
            end
        end
    end

    // Status decode straight from the state register.
    assign bus.armed     = (state == S_ARMED);
    assign bus.busy      = (state == S_DELAY) || (state == S_PULSE) || (state == S_GAP);
    assign bus.gl_en     = gl_en;
    assign bus.gl_mode   = gl_mode;
    assign bus.done      = done;
    assign bus.pulse_cnt = pulse_cnt;

endmodule
